// File: rtl/alu_op_sequencer.sv
// Multi-word command sequencer for a WIDTH-bit combinational alu, carry chained in this block.
// Latency: accept at edge T, rsp_valid from cycle T+NWORDS+1; at least NWORDS+2 cycles per command.
// Backpressure: cmd_ready only in IDLE; rsp_* held stable while rsp_valid && !rsp_ready.
module alu_op_sequencer #(
    parameter int WIDTH  = 16,
    parameter int NWORDS = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [3:0]               cmd_select,
    input  logic                     cmd_mode,
    input  logic                     cmd_carry_in,
    input  logic                     cmd_chain,
    input  logic [WIDTH*NWORDS-1:0]  cmd_a,
    input  logic [WIDTH*NWORDS-1:0]  cmd_b,
    output logic [WIDTH-1:0]         alu_in_a,
    output logic [WIDTH-1:0]         alu_in_b,
    output logic [3:0]               alu_select,
    output logic                     alu_mode,
    output logic                     alu_carry_in,
    input  logic [WIDTH-1:0]         alu_out,
    input  logic                     alu_carry_out,
    input  logic                     alu_compare,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH*NWORDS-1:0]  rsp_data,
    output logic                     rsp_carry,
    output logic                     rsp_equal
);

    localparam int TW = WIDTH * NWORDS;
    localparam int KW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NWORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Latched command. Operands shift right one word per EXEC cycle so word k
    // always sits in the low WIDTH bits.
    logic [3:0]     sel_q;
    logic           mode_q;
    logic           cin_q;
    logic           chain_q;
    logic [TW-1:0]  a_q;
    logic [TW-1:0]  b_q;
    logic [KW-1:0]  k_q;

    // Accumulators; they double as the response registers and hold after the handshake.
    logic [TW-1:0]  res_q;
    logic           carry_q;
    logic           eq_q;

    // Per-word chain arithmetic (the alu add codes ignore carry_in, so the
    // incoming carry is added here).
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] word;
    logic             carry_nxt;
    logic [TW-1:0]    res_nxt;

    // Word result, carry out and the result register with word k shifted in at the top.
    always_comb begin
        sum       = {1'b0, alu_out} + {{WIDTH{1'b0}}, carry_q};
        word      = alu_out;
        carry_nxt = alu_carry_out;
        if (chain_q) begin
            word      = sum[WIDTH-1:0];
            carry_nxt = alu_carry_out | (carry_q & (&alu_out));
        end
        res_nxt = res_q >> WIDTH;
        res_nxt[TW-1 -: WIDTH] = word;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake/alu pin decode; alu pins are zero outside EXEC.
    always_comb begin
        state_nxt    = state;
        cmd_ready    = 1'b0;
        rsp_valid    = 1'b0;
        alu_in_a     = '0;
        alu_in_b     = '0;
        alu_select   = 4'd0;
        alu_mode     = 1'b0;
        alu_carry_in = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_in_a     = a_q[WIDTH-1:0];
                alu_in_b     = b_q[WIDTH-1:0];
                alu_select   = sel_q;
                alu_mode     = mode_q;
                alu_carry_in = cin_q;
                if (k_q == K_LAST) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Command latch on accept, then one word captured per EXEC cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q   <= 4'd0;
            mode_q  <= 1'b0;
            cin_q   <= 1'b0;
            chain_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            k_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            if (state == S_IDLE && cmd_valid) begin
                sel_q   <= cmd_select;
                mode_q  <= cmd_mode;
                cin_q   <= cmd_carry_in;
                chain_q <= cmd_chain;
                a_q     <= cmd_a;
                b_q     <= cmd_b;
                k_q     <= '0;
                res_q   <= '0;
                carry_q <= cmd_chain & cmd_carry_in;
                eq_q    <= 1'b1;
            end else if (state == S_EXEC) begin
                a_q     <= a_q >> WIDTH;
                b_q     <= b_q >> WIDTH;
                k_q     <= k_q + 1'b1;
                res_q   <= res_nxt;
                carry_q <= carry_nxt;
                eq_q    <= eq_q & alu_compare;
            end
        end
    end

    assign rsp_data  = res_q;
    assign rsp_carry = carry_q;
    assign rsp_equal = eq_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural alu stand-in plus a full-width reference of each operation.
// Latency: checks first rsp_valid at cycle T+NWORDS+1 and NWORDS+2 back-to-back spacing.
// Backpressure: holds rsp_ready low and verifies the response and cmd_ready stay put.
module tb_alu_op_sequencer;

    localparam int WIDTH  = 16;
    localparam int NWORDS = 2;
    localparam int TW     = WIDTH * NWORDS;

    logic            clk = 1'b0;
    logic            rst;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [3:0]      cmd_select;
    logic            cmd_mode;
    logic            cmd_carry_in;
    logic            cmd_chain;
    logic [TW-1:0]   cmd_a;
    logic [TW-1:0]   cmd_b;
    logic [WIDTH-1:0] alu_in_a;
    logic [WIDTH-1:0] alu_in_b;
    logic [3:0]      alu_select;
    logic            alu_mode;
    logic            alu_carry_in;
    logic [WIDTH-1:0] alu_out;
    logic            alu_carry_out;
    logic            alu_compare;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [TW-1:0]   rsp_data;
    logic            rsp_carry;
    logic            rsp_equal;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.WIDTH(WIDTH), .NWORDS(NWORDS)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_select(cmd_select), .cmd_mode(cmd_mode),
        .cmd_carry_in(cmd_carry_in), .cmd_chain(cmd_chain),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_in_a(alu_in_a), .alu_in_b(alu_in_b),
        .alu_select(alu_select), .alu_mode(alu_mode), .alu_carry_in(alu_carry_in),
        .alu_out(alu_out), .alu_carry_out(alu_carry_out), .alu_compare(alu_compare),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_equal(rsp_equal)
    );

    // Stand-in for the combinational alu: add ignores carry_in, logic ops give carry 0.
    always_comb begin
        alu_out       = '0;
        alu_carry_out = 1'b0;
        alu_compare   = (alu_in_a == alu_in_b);
        if (!alu_mode && alu_select == 4'b1001) begin
            {alu_carry_out, alu_out} = {1'b0, alu_in_a} + {1'b0, alu_in_b};
        end else if (alu_mode) begin
            case (alu_select)
                4'b0110: alu_out = alu_in_a ^ alu_in_b;
                4'b1011: alu_out = alu_in_a & alu_in_b;
                4'b1110: alu_out = alu_in_a | alu_in_b;
                default: alu_out = ~alu_in_a;
            endcase
        end
    end

    // Whole-operation reference: returns {equal, carry, data}.
    function automatic logic [TW+1:0] ref_op(input logic [3:0] sel, input logic mode,
                                             input logic cin, input logic chain,
                                             input logic [TW-1:0] a, input logic [TW-1:0] b);
        logic [TW:0]     full;
        logic [TW-1:0]   f;
        logic [WIDTH:0]  lo;
        logic [WIDTH:0]  hi;
        if (!mode && sel == 4'b1001) begin
            if (chain) begin
                full = {1'b0, a} + {1'b0, b} + {{TW{1'b0}}, cin};
            end else begin
                lo   = {1'b0, a[WIDTH-1:0]} + {1'b0, b[WIDTH-1:0]};
                hi   = {1'b0, a[TW-1:WIDTH]} + {1'b0, b[TW-1:WIDTH]};
                full = {hi[WIDTH], hi[WIDTH-1:0], lo[WIDTH-1:0]};
            end
        end else begin
            case (sel)
                4'b0110: f = a ^ b;
                4'b1011: f = a & b;
                4'b1110: f = a | b;
                default: f = ~a;
            endcase
            full = chain ? ({1'b0, f} + {{TW{1'b0}}, cin}) : {1'b0, f};
        end
        return {(a == b), full};
    endfunction

    // Drive a random legal command onto cmd_* (cmd_valid untouched).
    task automatic rand_cmd();
        int op;
        int pat;
        logic [TW-1:0] a;
        logic [TW-1:0] b;
        op  = $urandom_range(0, 3);
        pat = $urandom_range(0, 4);
        a   = $urandom;
        b   = $urandom;
        case (pat)
            0: b = a;
            1: begin a = a | 32'hFFFF_0000; b = b & 32'h0000_FFFF; end
            2: begin a = 32'hFFFF_FFFF; b = 32'd0; end
            3: a = a | 32'h0000_FFFF;
            default: ;
        endcase
        case (op)
            0: begin cmd_select = 4'b1001; cmd_mode = 1'b0; end
            1: begin cmd_select = 4'b0110; cmd_mode = 1'b1; end
            2: begin cmd_select = 4'b1011; cmd_mode = 1'b1; end
            default: begin cmd_select = 4'b1110; cmd_mode = 1'b1; end
        endcase
        cmd_chain    = (op == 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) == 0);
        cmd_carry_in = 1'($urandom_range(0, 1));
        cmd_a        = a;
        cmd_b        = b;
    endtask

    // Issue the command currently on cmd_*, wait for the response and take it.
    // lat counts cycles from the accept edge to first rsp_valid (-1 on timeout).
    task automatic run_op(output logic [TW-1:0] d, output logic c, output logic e, output int lat);
        int g;
        @(negedge clk);
        cmd_valid = 1'b1;
        g = 0;
        while (!cmd_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid || g >= 50) lat = -1;
        d = rsp_data;
        c = rsp_carry;
        e = rsp_equal;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        cmd_a = 32'hDEAD_BEEF;
        cmd_b = 32'h1234_5678;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
        n_tests++;
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        n_tests++;
        if ({rsp_data, rsp_carry, rsp_equal} !== '0) begin
            n_fail++; $display("FAIL reset_rsp got %h/%b/%b want 0", rsp_data, rsp_carry, rsp_equal);
        end
        n_tests++;
        if ({alu_in_a, alu_in_b, alu_select, alu_mode, alu_carry_in} !== '0) begin
            n_fail++; $display("FAIL reset_alu_pins got a=%h b=%h s=%b", alu_in_a, alu_in_b, alu_select);
        end
    endtask

    task automatic test_directed();
        logic [TW-1:0] d;
        logic c;
        logic e;
        int lat;
        // 0x0001FFFF + 1 with chaining
        cmd_select = 4'b1001; cmd_mode = 1'b0; cmd_chain = 1'b1; cmd_carry_in = 1'b0;
        cmd_a = 32'h0001_FFFF; cmd_b = 32'h0000_0001;
        run_op(d, c, e, lat);
        n_tests++;
        if ({e, c, d} !== {1'b0, 1'b0, 32'h0002_0000}) begin
            n_fail++; $display("FAIL add_chain got %h c=%b e=%b want 00020000 c=0 e=0", d, c, e);
        end
        n_tests++;
        if (lat !== NWORDS + 1) begin n_fail++; $display("FAIL add_latency got %0d want %0d", lat, NWORDS + 1); end
        // all-ones wrap with final carry
        cmd_a = 32'hFFFF_FFFF; cmd_b = 32'h0000_0001;
        run_op(d, c, e, lat);
        n_tests++;
        if ({e, c, d} !== {1'b0, 1'b1, 32'h0000_0000}) begin
            n_fail++; $display("FAIL add_wrap got %h c=%b e=%b want 00000000 c=1 e=0", d, c, e);
        end
        // xor of equal operands
        cmd_select = 4'b0110; cmd_mode = 1'b1; cmd_chain = 1'b0;
        cmd_a = 32'h1234_5678; cmd_b = 32'h1234_5678;
        run_op(d, c, e, lat);
        n_tests++;
        if ({e, c, d} !== {1'b1, 1'b0, 32'h0000_0000}) begin
            n_fail++; $display("FAIL xor_equal got %h c=%b e=%b want 00000000 c=0 e=1", d, c, e);
        end
    endtask

    task automatic test_exec_pins();
        logic [TW+1:0] exp;
        int g;
        cmd_select = 4'b1001; cmd_mode = 1'b0; cmd_chain = 1'b0; cmd_carry_in = 1'b1;
        cmd_a = 32'hAAAA_5555; cmd_b = 32'h1234_0F0F;
        exp = ref_op(cmd_select, cmd_mode, cmd_carry_in, cmd_chain, cmd_a, cmd_b);
        @(negedge clk);
        cmd_valid = 1'b1;
        g = 0;
        while (!cmd_ready && g < 50) begin @(negedge clk); g++; end
        @(negedge clk);
        cmd_valid = 1'b0;
        n_tests++;
        if ({alu_in_a, alu_in_b, alu_select, alu_mode, alu_carry_in, cmd_ready} !==
            {16'h5555, 16'h0F0F, 4'b1001, 1'b0, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL exec_word0 got a=%h b=%h s=%b m=%b ci=%b rdy=%b", alu_in_a, alu_in_b,
                               alu_select, alu_mode, alu_carry_in, cmd_ready);
        end
        @(negedge clk);
        n_tests++;
        if ({alu_in_a, alu_in_b, alu_carry_in} !== {16'hAAAA, 16'h1234, 1'b1}) begin
            n_fail++; $display("FAIL exec_word1 got a=%h b=%h ci=%b", alu_in_a, alu_in_b, alu_carry_in);
        end
        @(negedge clk);
        n_tests++;
        if ({rsp_valid, alu_in_a, alu_select, alu_carry_in} !== {1'b1, 16'h0, 4'h0, 1'b0}) begin
            n_fail++; $display("FAIL done_pins got v=%b a=%h s=%b ci=%b", rsp_valid, alu_in_a, alu_select, alu_carry_in);
        end
        n_tests++;
        if ({rsp_equal, rsp_carry, rsp_data} !== exp) begin
            n_fail++; $display("FAIL nochain_cin got %b%b_%h want %h", rsp_equal, rsp_carry, rsp_data, exp);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [TW+1:0] exp1;
        logic [TW+1:0] exp2;
        logic [TW+1:0] held;
        logic [TW-1:0] a2;
        logic [TW-1:0] b2;
        int g;
        int lat;
        cmd_select = 4'b1001; cmd_mode = 1'b0; cmd_chain = 1'b1; cmd_carry_in = 1'b1;
        cmd_a = $urandom; cmd_b = $urandom;
        exp1 = ref_op(cmd_select, cmd_mode, cmd_carry_in, cmd_chain, cmd_a, cmd_b);
        a2 = $urandom; b2 = $urandom;
        exp2 = ref_op(4'b0110, 1'b1, 1'b0, 1'b0, a2, b2);
        @(negedge clk);
        cmd_valid = 1'b1;
        g = 0;
        while (!cmd_ready && g < 50) begin @(negedge clk); g++; end
        @(negedge clk);
        // second command offered immediately and kept asserted
        cmd_select = 4'b0110; cmd_mode = 1'b1; cmd_chain = 1'b0; cmd_carry_in = 1'b0;
        cmd_a = a2; cmd_b = b2;
        g = 0;
        while (!rsp_valid && g < 20) begin @(negedge clk); g++; end
        held = {rsp_equal, rsp_carry, rsp_data};
        n_tests++;
        if (held !== exp1) begin n_fail++; $display("FAIL bp_first got %h want %h", held, exp1); end
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if ({rsp_valid, cmd_ready, rsp_equal, rsp_carry, rsp_data} !== {1'b1, 1'b0, exp1}) begin
                n_fail++; $display("FAIL bp_hold%0d got v=%b rdy=%b %b%b_%h want v=1 rdy=0 %h", i, rsp_valid,
                                   cmd_ready, rsp_equal, rsp_carry, rsp_data, exp1);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        n_tests++;
        if ({rsp_valid, cmd_ready, rsp_data} !== {1'b0, 1'b1, exp1[TW-1:0]}) begin
            n_fail++; $display("FAIL bp_release got v=%b rdy=%b d=%h want v=0 rdy=1 d=%h", rsp_valid, cmd_ready,
                               rsp_data, exp1[TW-1:0]);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        n_tests++;
        if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL bp_second_accept got rdy=%b want 0", cmd_ready); end
        lat = 1;
        while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
        n_tests++;
        if ({lat, rsp_equal, rsp_carry, rsp_data} !== {NWORDS + 1, exp2}) begin
            n_fail++; $display("FAIL bp_second got lat=%0d %b%b_%h want lat=%0d %h", lat, rsp_equal, rsp_carry,
                               rsp_data, NWORDS + 1, exp2);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_exec();
        int g;
        int seen;
        rand_cmd();
        @(negedge clk);
        cmd_valid = 1'b1;
        g = 0;
        while (!cmd_ready && g < 50) begin @(negedge clk); g++; end
        @(negedge clk);
        cmd_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_tests++;
        if ({cmd_ready, rsp_valid, alu_in_a, alu_select} !== {1'b1, 1'b0, 16'h0, 4'h0}) begin
            n_fail++; $display("FAIL midreset_idle got rdy=%b v=%b a=%h s=%b want rdy=1 v=0", cmd_ready, rsp_valid,
                               alu_in_a, alu_select);
        end
        rsp_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        rsp_ready = 1'b0;
        n_tests++;
        if (seen !== 0) begin n_fail++; $display("FAIL midreset_no_rsp got %0d responses want 0", seen); end
    endtask

    task automatic test_random();
        logic [TW+1:0] exp;
        logic [TW-1:0] d;
        logic c;
        logic e;
        int lat;
        for (int i = 0; i < 40; i++) begin
            rand_cmd();
            exp = ref_op(cmd_select, cmd_mode, cmd_carry_in, cmd_chain, cmd_a, cmd_b);
            run_op(d, c, e, lat);
            n_tests++;
            if ({e, c, d} !== exp || lat != NWORDS + 1) begin
                n_fail++;
                $display("FAIL rand%0d sel=%b m=%b ch=%b ci=%b a=%h b=%h got %b%b_%h lat=%0d want %h lat=%0d", i,
                         cmd_select, cmd_mode, cmd_chain, cmd_carry_in, cmd_a, cmd_b, e, c, d, lat, exp, NWORDS + 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [TW+1:0] exp_q[$];
        logic [TW+1:0] exp;
        int acc_cyc[$];
        int issued;
        int got;
        int cyc;
        bit pend;
        issued = 0; got = 0; cyc = 0; pend = 0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rand_cmd();
        cmd_valid = 1'b1;
        while (got < 5 && cyc < 200) begin
            if (rsp_valid) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL b2b_extra_rsp got %h want none", rsp_data);
                end else begin
                    exp = exp_q.pop_front();
                    if ({rsp_equal, rsp_carry, rsp_data} !== exp) begin
                        n_fail++; $display("FAIL b2b_rsp%0d got %b%b_%h want %h", got, rsp_equal, rsp_carry,
                                           rsp_data, exp);
                    end
                end
                got++;
            end
            if (cmd_valid && cmd_ready) begin
                exp_q.push_back(ref_op(cmd_select, cmd_mode, cmd_carry_in, cmd_chain, cmd_a, cmd_b));
                acc_cyc.push_back(cyc);
                issued++;
                pend = 1'b1;
            end
            @(negedge clk);
            cyc++;
            if (pend) begin
                pend = 1'b0;
                if (issued < 5) rand_cmd();
                else cmd_valid = 1'b0;
            end
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        n_tests++;
        if (got !== 5) begin n_fail++; $display("FAIL b2b_count got %0d want 5", got); end
        for (int i = 1; i < acc_cyc.size(); i++) begin
            n_tests++;
            if (acc_cyc[i] - acc_cyc[i-1] !== NWORDS + 2) begin
                n_fail++; $display("FAIL b2b_spacing%0d got %0d want %0d", i, acc_cyc[i] - acc_cyc[i-1], NWORDS + 2);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        cmd_select = 4'd0;
        cmd_mode = 1'b0;
        cmd_carry_in = 1'b0;
        cmd_chain = 1'b0;
        cmd_a = '0;
        cmd_b = '0;
        repeat (3) @(negedge clk);
        test_reset();
        test_directed();
        test_exec_pins();
        test_backpressure();
        test_reset_mid_exec();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
